// File: rtl/snn_pkg.sv
// Shared types and helpers for the neuron weight-loading path.
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_WAIT,
    RD_CAP,
    DONE
  } loader_state_t;

  // Index width for n items; a single item still needs one bit of select.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/weight_loader_if.sv
// Weight stream (valid/ready) plus neuron weight-memory port.
// master = the loader (stream sink, memory initiator); slave = stream source and memory side.
interface weight_loader_if #(
  parameter int WEIGHT_SIZE       = 32,
  parameter int WEIGHT_ADDR_WIDTH = 8,
  parameter int SEL_W             = 2
);
  logic                         s_valid;
  logic                         s_ready;
  logic [WEIGHT_SIZE-1:0]       s_data;
  logic [WEIGHT_ADDR_WIDTH-1:0] mem_addr;
  logic [WEIGHT_SIZE-1:0]       mem_din;
  logic                         mem_wen;
  logic [WEIGHT_SIZE-1:0]       mem_dout;
  logic [SEL_W-1:0]             neuron_sel;

  modport master (
    input  s_valid, s_data, mem_dout,
    output s_ready, mem_addr, mem_din, mem_wen, neuron_sel
  );

  modport slave (
    output s_valid, s_data, mem_dout,
    input  s_ready, mem_addr, mem_din, mem_wen, neuron_sel
  );
endinterface

// File: rtl/weight_addr_gen.sv
// Two-level slot/neuron counter shared by the write pass and the read-back pass.
// slot counts 0..NUM_INPUTS-1; on its wrap the neuron index advances (and wraps).
module weight_addr_gen
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_NEURONS = 4,
  parameter int SLOT_W      = sel_width(NUM_INPUTS),
  parameter int SEL_W       = sel_width(NUM_NEURONS)
) (
  input  logic              mem_clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  output logic [SLOT_W-1:0] slot,
  output logic [SEL_W-1:0]  neuron,
  output logic              last
);

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [SEL_W-1:0]  neuron_q, neuron_d;
  logic              slot_last, neuron_last;

  assign slot_last   = (slot_q == SLOT_W'(NUM_INPUTS - 1));
  assign neuron_last = (neuron_q == SEL_W'(NUM_NEURONS - 1));

  // Next count: clear wins over advance; slot wrap carries into the neuron index.
  always_comb begin
    slot_d   = slot_q;
    neuron_d = neuron_q;
    if (clr) begin
      slot_d   = '0;
      neuron_d = '0;
    end else if (adv) begin
      if (slot_last) begin
        slot_d   = '0;
        neuron_d = neuron_last ? '0 : neuron_q + 1'b1;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge mem_clk) begin
    if (!rst) begin
      slot_q   <= '0;
      neuron_q <= '0;
    end else begin
      slot_q   <= slot_d;
      neuron_q <= neuron_d;
    end
  end

  assign slot   = slot_q;
  assign neuron = neuron_q;
  assign last   = slot_last && neuron_last;

endmodule

// File: rtl/weight_loader.sv
// Streams weight words into NUM_INPUTS slots of each of NUM_NEURONS neurons.
// Optional read-back checksum pass compiled in with WEIGHT_LOADER_VERIFY_EN.
//
// state    | meaning
// IDLE     | waiting for start; busy low
// WRITE    | accepting words, one memory write per handshake
// RD_ISSUE | (verify) drive read address/select
// RD_WAIT  | (verify) neuron registers its read data
// RD_CAP   | (verify) accumulate mem_dout, advance slot
// DONE     | raise done for one cycle, return to IDLE
module weight_loader
  import snn_pkg::*;
#(
  parameter int WEIGHT_SIZE       = 32,
  parameter int WEIGHT_ADDR_WIDTH = 8,
  parameter int NUM_INPUTS        = 4,
  parameter int NUM_NEURONS       = 4
) (
  input  logic mem_clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic error,
  weight_loader_if.master bus
);

  localparam int SEL_W  = sel_width(NUM_NEURONS);
  localparam int SLOT_W = sel_width(NUM_INPUTS);

  loader_state_t                state_q, state_d;
  logic [WEIGHT_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WEIGHT_SIZE-1:0]       mem_din_q, mem_din_d;
  logic                         mem_wen_q, mem_wen_d;
  logic [SEL_W-1:0]             neuron_sel_q, neuron_sel_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         cnt_clr, cnt_adv, cnt_last;
  logic [SLOT_W-1:0]            slot;
  logic [SEL_W-1:0]             neuron;
`ifdef WEIGHT_LOADER_VERIFY_EN
  logic [WEIGHT_SIZE-1:0]       wsum_q, wsum_d;
  logic [WEIGHT_SIZE-1:0]       rsum_q, rsum_d;
  logic                         error_q, error_d;
`endif

  weight_addr_gen #(
    .NUM_INPUTS  (NUM_INPUTS),
    .NUM_NEURONS (NUM_NEURONS),
    .SLOT_W      (SLOT_W),
    .SEL_W       (SEL_W)
  ) u_addr_gen (
    .mem_clk (mem_clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .adv     (cnt_adv),
    .slot    (slot),
    .neuron  (neuron),
    .last    (cnt_last)
  );

  assign bus.s_ready = (state_q == WRITE);

  // Next-state and next-output logic; write strobe and done default to a single-cycle pulse.
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    mem_wen_d    = 1'b0;
    neuron_sel_d = neuron_sel_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cnt_clr      = 1'b0;
    cnt_adv      = 1'b0;
`ifdef WEIGHT_LOADER_VERIFY_EN
    wsum_d       = wsum_q;
    rsum_d       = rsum_q;
    error_d      = error_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        // The done pulse cycle is still treated as end-of-run, so start is not taken there.
        if (start && !done_q) begin
          state_d = WRITE;
          cnt_clr = 1'b1;
          busy_d  = 1'b1;
`ifdef WEIGHT_LOADER_VERIFY_EN
          wsum_d  = '0;
          rsum_d  = '0;
          error_d = 1'b0;
`endif
        end
      end
      WRITE: begin
        if (bus.s_valid) begin
          mem_wen_d    = 1'b1;
          mem_addr_d   = WEIGHT_ADDR_WIDTH'(slot);
          mem_din_d    = bus.s_data;
          neuron_sel_d = neuron;
          cnt_adv      = 1'b1;
`ifdef WEIGHT_LOADER_VERIFY_EN
          wsum_d       = wsum_q + bus.s_data;
          if (cnt_last) begin
            state_d = RD_ISSUE;
            cnt_clr = 1'b1;
          end
`else
          if (cnt_last) state_d = DONE;
`endif
        end
      end
`ifdef WEIGHT_LOADER_VERIFY_EN
      RD_ISSUE: begin
        mem_addr_d   = WEIGHT_ADDR_WIDTH'(slot);
        neuron_sel_d = neuron;
        state_d      = RD_WAIT;
      end
      RD_WAIT: state_d = RD_CAP;
      RD_CAP: begin
        rsum_d  = rsum_q + bus.mem_dout;
        cnt_adv = 1'b1;
        if (cnt_last) begin
          state_d = DONE;
          error_d = (wsum_q != rsum_d);
        end else begin
          state_d = RD_ISSUE;
        end
      end
`endif
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge mem_clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_wen_q    <= 1'b0;
      neuron_sel_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef WEIGHT_LOADER_VERIFY_EN
      wsum_q       <= '0;
      rsum_q       <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      mem_wen_q    <= mem_wen_d;
      neuron_sel_q <= neuron_sel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef WEIGHT_LOADER_VERIFY_EN
      wsum_q       <= wsum_d;
      rsum_q       <= rsum_d;
      error_q      <= error_d;
`endif
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = mem_din_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.neuron_sel = neuron_sel_q;
  assign busy           = busy_q;
  assign done           = done_q;
`ifdef WEIGHT_LOADER_VERIFY_EN
  assign error          = error_q;
`else
  // Without the read-back pass there is nothing to compare and read data is not consumed.
  logic unused_dout;
  assign unused_dout = ^bus.mem_dout;
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader with a write scoreboard and a behavioural neuron memory.
module tb_weight_loader;

  localparam int NI = 4;
  localparam int NN = 2;
  localparam int WS = 32;
  localparam int AW = 8;
  localparam int SW = 1;
`ifdef WEIGHT_LOADER_VERIFY_EN
  localparam bit VERIFY   = 1'b1;
  localparam int DONE_LAT = 1 + 3 * NI * NN;
`else
  localparam bit VERIFY   = 1'b0;
  localparam int DONE_LAT = 1;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [SW-1:0] sel;
    logic [WS-1:0] data;
  } wr_t;

  logic mem_clk = 1'b0;
  logic rst     = 1'b0;
  logic start   = 1'b0;
  logic busy, done, error;
  bit   corrupt = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int run_writes = 0;
  int first_cyc  = 0;
  int last_cyc   = 0;
  int rd_evt     = 0;
  int word_idx   = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [SW-1:0] prev_sel  = '0;
  wr_t exp_q[$];
  logic [WS-1:0] mem [NN][NI];

  weight_loader_if #(.WEIGHT_SIZE(WS), .WEIGHT_ADDR_WIDTH(AW), .SEL_W(SW)) bus ();

  weight_loader #(
    .WEIGHT_SIZE       (WS),
    .WEIGHT_ADDR_WIDTH (AW),
    .NUM_INPUTS        (NI),
    .NUM_NEURONS       (NN)
  ) dut (
    .mem_clk (mem_clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .bus     (bus.master)
  );

  always #5 mem_clk = ~mem_clk;

  always @(posedge mem_clk) cyc <= cyc + 1;

  // Neuron memory: write on mem_wen, registered read with one-cycle latency.
  always @(posedge mem_clk) begin
    if (bus.mem_wen) mem[bus.neuron_sel][bus.mem_addr[1:0]] <= bus.mem_din;
    bus.mem_dout <= mem[bus.neuron_sel][bus.mem_addr[1:0]] +
                    ((corrupt && bus.neuron_sel == 1'b1 && bus.mem_addr == 8'd2) ? 32'd1 : 32'd0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every mem_wen cycle must match the oldest accepted word.
  initial begin
    forever begin
      @(negedge mem_clk);
      if (bus.mem_wen) begin
        if (run_writes == 0) first_cyc = cyc;
        last_cyc = cyc;
        run_writes++;
        check("write_has_handshake", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", bus.mem_addr, e.addr);
          check("wr_sel", bus.neuron_sel, e.sel);
          check("wr_data", bus.mem_din, e.data);
        end
      end else if (bus.mem_addr != prev_addr || bus.neuron_sel != prev_sel) begin
        rd_evt++;
      end
      prev_addr = bus.mem_addr;
      prev_sel  = bus.neuron_sel;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "simulation timeout");
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge mem_clk); #1;
    start      = 1'b0;
    run_writes = 0;
    word_idx   = 0;
    check("busy_after_start", busy, 1'b1);
    check("error_cleared_by_start", error, 1'b0);
    check("s_ready_in_write", bus.s_ready, 1'b1);
  endtask

  task automatic send_word(input logic [WS-1:0] d, input int gap, input bit pulse_start);
    bit acc;
    acc = 1'b0;
    bus.s_valid = 1'b0;
    repeat (gap) begin @(posedge mem_clk); #1; end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    start       = pulse_start;
    for (int n = 0; n < 50; n++) begin
      @(negedge mem_clk);
      if (bus.s_ready) begin
        exp_q.push_back('{addr: AW'(word_idx % NI), sel: SW'((word_idx / NI) % NN), data: d});
        word_idx++;
        acc = 1'b1;
        break;
      end
      @(posedge mem_clk); #1;
    end
    check("handshake_accepted", acc, 1'b1);
    @(posedge mem_clk); #1;
    bus.s_valid = 1'b0;
    start       = 1'b0;
  endtask

  // Called in the cycle holding the last write; measures cycles until done.
  task automatic finish_run(input bit exp_err);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge mem_clk);
      if (done) break;
      @(posedge mem_clk); #1;
      n++;
    end
    check("done_latency", n, DONE_LAT);
    check("busy_at_done", busy, 1'b1);
    check("error_at_done", error, exp_err);
    @(posedge mem_clk); #1;
    @(negedge mem_clk);
    check("busy_after_done", busy, 1'b0);
    check("done_single_pulse", done, 1'b0);
    check("queue_drained", exp_q.size(), 0);
    @(posedge mem_clk); #1;
  endtask

  task automatic check_mem(input int base);
    for (int n = 0; n < NN; n++)
      for (int s = 0; s < NI; s++)
        check("mem_content", mem[n][s], base + n * NI + s);
  endtask

  initial begin
    int gaps[8];
    gaps = '{0, 2, 0, 1, 0, 2, 0, 1};
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge mem_clk);
    #1;
    check("rst_mem_wen", bus.mem_wen, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_sel", bus.neuron_sel, 0);
    check("rst_s_ready", bus.s_ready, 1'b0);
    rst = 1'b1;

    // Valid in IDLE without start: no handshake, no write
    bus.s_valid = 1'b1;
    bus.s_data  = 32'd55;
    repeat (3) begin
      @(negedge mem_clk);
      check("idle_s_ready", bus.s_ready, 1'b0);
      @(posedge mem_clk); #1;
    end
    bus.s_valid = 1'b0;
    check("idle_no_writes", run_writes, 0);
    check("idle_busy", busy, 1'b0);

    // Continuous stream 1..8
    do_start();
    rd_evt = 0;
    for (int w = 1; w <= 8; w++) send_word(WS'(w), 0, 1'b0);
    finish_run(1'b0);
    check("cont_writes", run_writes, 8);
    check("cont_consecutive", last_cyc - first_cyc, 7);
    check("read_pass_seen", rd_evt != 0, VERIFY);
    check_mem(1);

    // Backpressure 10..17, start pulsed mid-run
    do_start();
    for (int i = 0; i < 8; i++) send_word(WS'(10 + i), gaps[i], i == 3);
    finish_run(1'b0);
    check("bp_writes", run_writes, 8);
    check_mem(10);

    // Reset after three accepted words, with a word in flight
    do_start();
    for (int i = 0; i < 3; i++) send_word(WS'(30 + i), 0, 1'b0);
    rst = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'd99;
    @(posedge mem_clk); #1;
    rst = 1'b1;
    bus.s_valid = 1'b0;
    check("midrst_mem_wen", bus.mem_wen, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_addr", bus.mem_addr, 0);
    check("midrst_sel", bus.neuron_sel, 0);
    check("midrst_s_ready", bus.s_ready, 1'b0);
    repeat (3) begin @(posedge mem_clk); #1; end
    check("midrst_writes", run_writes, 3);
    check("midrst_busy_stays_low", busy, 1'b0);
    do_start();
    for (int i = 0; i < 8; i++) send_word(WS'(20 + i), 0, 1'b0);
    finish_run(1'b0);
    check("rerun_writes", run_writes, 8);
    check_mem(20);

    // Corrupted read of neuron 1 slot 2: error only when read-back is compiled in
    corrupt = 1'b1;
    do_start();
    for (int w = 1; w <= 8; w++) send_word(WS'(w), 0, 1'b0);
    finish_run(VERIFY);
    repeat (3) begin @(posedge mem_clk); #1; end
    check("error_sticky", error, VERIFY);
    corrupt = 1'b0;
    do_start();
    for (int w = 1; w <= 8; w++) send_word(WS'(w), 0, 1'b0);
    finish_run(1'b0);
    check_mem(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
